// File: rtl/apb_cmd_parser_if.sv
// rtl/apb_cmd_parser_if.sv - command handshake bundle between the frame parser and the APB master
interface apb_cmd_parser_if #(
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4
);
  logic [SEL_WIDTH-1:0]    p_sel;
  logic                    p_write;
  logic [8*ADDR_BYTES-1:0] p_addr;
  logic [8*DATA_BYTES-1:0] p_wdata;
  logic                    o_valid;
  logic                    m_ready;

  modport master (output p_sel, p_write, p_addr, p_wdata, o_valid, input m_ready);
  modport slave  (input p_sel, p_write, p_addr, p_wdata, o_valid, output m_ready);
endinterface

// File: rtl/apb_cmd_parser.sv
// rtl/apb_cmd_parser.sv - byte-stream to APB command parser with select check and back-pressure
module apb_cmd_parser #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int NUM_SLAVES = 3
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic             empty_flag,
  input  logic [7:0]       fifo_data,
  output logic             rd_en,
  output logic             o_err,
  output logic             o_busy,
  apb_cmd_parser_if.master cmd
);
  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int MAXB  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int IDX_W = $clog2(MAXB) + 1;
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(NUM_SLAVES);

  typedef enum logic [3:0] {
    SEL_REQ, SEL_CAP, WR_REQ, WR_CAP, ADDR_REQ, ADDR_CAP,
    DATA_REQ, DATA_CAP, OUT, ERR
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 drop, wr_sh;
  logic [SEL_WIDTH-1:0] sel_sh;
  logic [AW-1:0]        addr_sh, addr_nxt;
  logic [DW-1:0]        data_sh, data_nxt;
  logic                 sel_bad, addr_last, data_last;

  assign sel_bad   = (fifo_data[SEL_WIDTH-1:0] == '0) || (fifo_data[SEL_WIDTH-1:0] > MAX_SEL);
  assign addr_last = (idx == IDX_W'(ADDR_BYTES - 1));
  assign data_last = (idx == IDX_W'(DATA_BYTES - 1));
  assign o_busy    = (state != SEL_REQ);

  // Shift-in values including the byte being captured this cycle, so the
  // output registers can load a complete field on the last CAP.
  always_comb begin
    addr_nxt = addr_sh;
    data_nxt = data_sh;
    if (state == ADDR_CAP) addr_nxt = (addr_sh << 8) | AW'(fifo_data);
    if (state == DATA_CAP) data_nxt = (data_sh << 8) | DW'(fifo_data);
  end

  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    o_err       = 1'b0;
    cmd.o_valid = 1'b0;
    case (state)
      SEL_REQ: begin
        rd_en = ~empty_flag;
        if (!empty_flag) state_nxt = SEL_CAP;
      end
      SEL_CAP: state_nxt = WR_REQ;
      WR_REQ: begin
        rd_en = ~empty_flag;
        if (!empty_flag) state_nxt = WR_CAP;
      end
      WR_CAP: state_nxt = ADDR_REQ;
      ADDR_REQ: begin
        rd_en = ~empty_flag;
        if (!empty_flag) state_nxt = ADDR_CAP;
      end
      ADDR_CAP: begin
        if (!addr_last)  state_nxt = ADDR_REQ;
        else if (wr_sh)  state_nxt = DATA_REQ;
        else if (drop)   state_nxt = ERR;
        else             state_nxt = OUT;
      end
      DATA_REQ: begin
        rd_en = ~empty_flag;
        if (!empty_flag) state_nxt = DATA_CAP;
      end
      DATA_CAP: begin
        if (!data_last) state_nxt = DATA_REQ;
        else if (drop)  state_nxt = ERR;
        else            state_nxt = OUT;
      end
      OUT: begin
        cmd.o_valid = 1'b1;
        if (cmd.m_ready) state_nxt = SEL_REQ;
      end
      ERR: begin
        o_err     = 1'b1;
        state_nxt = SEL_REQ;
      end
      default: state_nxt = SEL_REQ;
    endcase
    if (rst) rd_en = 1'b0;
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state       <= SEL_REQ;
      idx         <= '0;
      drop        <= 1'b0;
      wr_sh       <= 1'b0;
      sel_sh      <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      cmd.p_sel   <= '0;
      cmd.p_write <= 1'b0;
      cmd.p_addr  <= '0;
      cmd.p_wdata <= '0;
    end else begin
      state   <= state_nxt;
      addr_sh <= addr_nxt;
      data_sh <= data_nxt;
      case (state)
        SEL_CAP: begin
          sel_sh <= fifo_data[SEL_WIDTH-1:0];
          drop   <= sel_bad;
        end
        WR_CAP: begin
          wr_sh <= fifo_data[0];
          idx   <= '0;
        end
        ADDR_CAP: idx <= addr_last ? '0 : idx + IDX_W'(1);
        DATA_CAP: idx <= data_last ? '0 : idx + IDX_W'(1);
        default: ;
      endcase
      // Command outputs change only when a complete legal frame is presented.
      if (state_nxt == OUT && state != OUT) begin
        cmd.p_sel   <= sel_sh;
        cmd.p_write <= wr_sh;
        cmd.p_addr  <= addr_nxt;
        cmd.p_wdata <= wr_sh ? data_nxt : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_cmd_parser.sv
// tb/tb_apb_cmd_parser.sv - scoreboard bench for two parser configurations
module tb_apb_cmd_parser;
  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic        rst;
  logic [1:0]  empty, rd_en, o_err, o_busy, stall, mr, ov, owr;
  logic [7:0]  fdata [2];
  logic [7:0]  mem [2][512];
  logic [7:0]  osel [2];
  logic [63:0] oaddr [2], odata [2];
  int          wp [2], rp [2], viol [2], errs [2], errv [2];
  int          total = 0, bad = 0;

  typedef struct {
    int          k;
    logic [7:0]  sel;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } cmd_t;
  cmd_t exp_q[$];

  apb_cmd_parser_if #(.SEL_WIDTH(2), .ADDR_BYTES(4), .DATA_BYTES(4)) c0 ();
  apb_cmd_parser_if #(.SEL_WIDTH(3), .ADDR_BYTES(2), .DATA_BYTES(8)) c1 ();

  apb_cmd_parser #(.ADDR_BYTES(4), .DATA_BYTES(4), .SEL_WIDTH(2), .NUM_SLAVES(3)) u0 (
    .rd_clk(rd_clk), .rst(rst), .empty_flag(empty[0]), .fifo_data(fdata[0]),
    .rd_en(rd_en[0]), .o_err(o_err[0]), .o_busy(o_busy[0]), .cmd(c0.master));
  apb_cmd_parser #(.ADDR_BYTES(2), .DATA_BYTES(8), .SEL_WIDTH(3), .NUM_SLAVES(2)) u1 (
    .rd_clk(rd_clk), .rst(rst), .empty_flag(empty[1]), .fifo_data(fdata[1]),
    .rd_en(rd_en[1]), .o_err(o_err[1]), .o_busy(o_busy[1]), .cmd(c1.master));

  assign empty[0]   = (wp[0] == rp[0]) || stall[0];
  assign empty[1]   = (wp[1] == rp[1]) || stall[1];
  assign c0.m_ready = mr[0];
  assign c1.m_ready = mr[1];
  assign ov         = {c1.o_valid, c0.o_valid};
  assign owr        = {c1.p_write, c0.p_write};
  assign osel[0]    = 8'(c0.p_sel);
  assign osel[1]    = 8'(c1.p_sel);
  assign oaddr[0]   = 64'(c0.p_addr);
  assign oaddr[1]   = 64'(c1.p_addr);
  assign odata[0]   = 64'(c0.p_wdata);
  assign odata[1]   = 64'(c1.p_wdata);

  // FIFO model: data appears the cycle after a pop; also tracks protocol events.
  always @(posedge rd_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k] && empty[k]) viol[k] <= viol[k] + 1;
      if (rd_en[k] && !empty[k]) begin
        fdata[k] <= mem[k][rp[k]];
        rp[k]    <= rp[k] + 1;
      end
      if (o_err[k]) errs[k] <= errs[k] + 1;
      if (o_err[k] && ov[k]) errv[k] <= errv[k] + 1;
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge rd_clk);
  endtask

  task automatic push_byte(int k, logic [7:0] b);
    mem[k][wp[k]] = b;
    wp[k]++;
  endtask

  task automatic push_frame(int k, logic [7:0] sb, logic [7:0] wb, logic [63:0] addr, logic [63:0] data);
    int         ab   = (k == 1) ? 2 : 4;
    int         db   = (k == 1) ? 8 : 4;
    int         ns   = (k == 1) ? 2 : 3;
    logic [7:0] mask = (k == 1) ? 8'h07 : 8'h03;
    logic [7:0] s;
    cmd_t       e;
    s = sb & mask;
    push_byte(k, sb);
    push_byte(k, wb);
    for (int i = ab - 1; i >= 0; i--) push_byte(k, addr[8*i +: 8]);
    if (wb[0]) for (int i = db - 1; i >= 0; i--) push_byte(k, data[8*i +: 8]);
    if (s != 8'h00 && int'(s) <= ns) begin
      e.k = k; e.sel = s; e.wr = wb[0]; e.addr = addr;
      e.wdata = wb[0] ? data : 64'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_valid(int k, int max, output int cyc);
    cyc = 0;
    while (!ov[k] && cyc < max) begin tick(); cyc++; end
    chk("valid_seen", 64'(ov[k]), 64'h1);
  endtask

  task automatic wait_err(int k, int max, int exp_cyc);
    int cyc = 0;
    while (!o_err[k] && cyc < max) begin tick(); cyc++; end
    chk("err_cycle", 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic check_cmd(int k);
    cmd_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty got=0 exp=1");
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("p_sel", 64'(osel[k]), 64'(e.sel));
    chk("p_write", 64'(owr[k]), 64'(e.wr));
    chk("p_addr", oaddr[k], e.addr);
    chk("p_wdata", odata[k], e.wdata);
  endtask

  task automatic expect_cmd(int k, int exp_cyc);
    int cyc;
    wait_valid(k, 400, cyc);
    if (exp_cyc >= 0) chk("valid_cycle", 64'(cyc), 64'(exp_cyc));
    check_cmd(k);
    tick();
    chk("valid_drop", 64'(ov[k]), 64'h0);
  endtask

  initial begin
    int r0, cyc, cnt, e0;
    rst = 1'b1; stall = 2'b00; mr = 2'b11;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_en", 64'(rd_en[k]), 0);  chk("rst_valid", 64'(ov[k]), 0);
      chk("rst_err", 64'(o_err[k]), 0);    chk("rst_busy", 64'(o_busy[k]), 0);
      chk("rst_sel", 64'(osel[k]), 0);     chk("rst_write", 64'(owr[k]), 0);
      chk("rst_addr", oaddr[k], 0);        chk("rst_wdata", odata[k], 0);
    end
    rst = 1'b0;
    tick();

    // Single write frame at full rate.
    r0 = rp[0];
    push_frame(0, 8'h01, 8'h01, 64'hDEADBEEF, 64'h12345678);
    expect_cmd(0, 20);
    chk("write_pops", 64'(rp[0] - r0), 64'd10);
    chk("idle_busy", 64'(o_busy[0]), 0);

    // Read frame carries no data bytes; the following write stays aligned.
    r0 = rp[0];
    push_frame(0, 8'h02, 8'h00, 64'h00001004, 64'h0);
    push_frame(0, 8'h03, 8'h01, 64'hCAFE0004, 64'h89ABCDEF);
    expect_cmd(0, 12);
    expect_cmd(0, -1);
    chk("rw_pops", 64'(rp[0] - r0), 64'd16);

    // Illegal select drops the frame; upper select bits are ignored.
    e0 = errs[0];
    push_frame(0, 8'h00, 8'h01, 64'h11111111, 64'h22222222);
    push_frame(0, 8'h05, 8'h01, 64'h33334444, 64'h55556666);
    wait_err(0, 100, 20);
    expect_cmd(0, 21);
    chk("err_count", 64'(errs[0] - e0), 64'd1);

    // Back-pressure: command held, no FIFO reads.
    mr[0] = 1'b0;
    push_frame(0, 8'h03, 8'h01, 64'h00C0FFEE, 64'hA5A55A5A);
    push_frame(0, 8'h01, 8'h00, 64'h00000020, 64'h0);
    wait_valid(0, 100, cyc);
    r0 = rp[0];
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("hold_valid", 64'(ov[0]), 64'h1);
      chk("hold_rd_en", 64'(rd_en[0]), 0);
      chk("hold_addr", oaddr[0], exp_q[0].addr);
      chk("hold_wdata", odata[0], exp_q[0].wdata);
    end
    chk("hold_pops", 64'(rp[0] - r0), 0);
    check_cmd(0);
    mr[0] = 1'b1;
    tick();
    chk("accept_drop", 64'(ov[0]), 0);
    expect_cmd(0, -1);

    // FIFO empty toggles every 3 cycles through the address phase.
    push_frame(0, 8'h02, 8'h01, 64'h87654321, 64'h0BADF00D);
    cnt = 0;
    while (!ov[0] && cnt < 300) begin
      tick(); cnt++;
      if (cnt >= 5 && cnt % 3 == 0) stall[0] = ~stall[0];
    end
    stall[0] = 1'b0;
    chk("stall_valid", 64'(ov[0]), 64'h1);
    check_cmd(0);
    tick();

    // Reset after byte 4; a fresh frame is pushed while reset is high.
    for (int i = 0; i < 4; i++) push_byte(0, 8'h01 + 8'(i));
    for (int i = 0; i < 4; i++) push_byte(1, 8'h01);
    repeat (12) tick();
    chk("part_busy0", 64'(o_busy[0]), 64'h1);
    chk("part_busy1", 64'(o_busy[1]), 64'h1);
    rst = 1'b1;
    r0 = rp[0];
    push_frame(0, 8'h01, 8'h01, 64'hFEEDFACE, 64'h0F0F0F0F);
    tick();
    chk("mid_rst_rd_en", 64'(rd_en[0]), 0);
    chk("mid_rst_pops", 64'(rp[0] - r0), 0);
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_busy", 64'(o_busy[k]), 0);  chk("mid_rst_valid", 64'(ov[k]), 0);
      chk("mid_rst_sel", 64'(osel[k]), 0);     chk("mid_rst_write", 64'(owr[k]), 0);
      chk("mid_rst_addr", oaddr[k], 0);        chk("mid_rst_wdata", odata[k], 0);
    end
    rst = 1'b0;
    expect_cmd(0, 20);

    // Second configuration: 2 address bytes, 8 data bytes, 3-bit select, 2 slaves.
    push_frame(1, 8'h02, 8'h01, 64'hBEEF, 64'h0123456789ABCDEF);
    expect_cmd(1, 24);
    push_frame(1, 8'h0A, 8'h00, 64'h1234, 64'h0);
    expect_cmd(1, 8);
    e0 = errs[1];
    push_frame(1, 8'h03, 8'h00, 64'h5555, 64'h0);
    push_frame(1, 8'h01, 8'h01, 64'hA0B0, 64'hFEDCBA9876543210);
    wait_err(1, 100, 8);
    expect_cmd(1, 25);
    chk("err_count1", 64'(errs[1] - e0), 64'd1);

    tick();
    chk("empty_rd_en0", 64'(viol[0]), 0);
    chk("empty_rd_en1", 64'(viol[1]), 0);
    chk("err_with_valid0", 64'(errv[0]), 0);
    chk("err_with_valid1", 64'(errv[1]), 0);
    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_cmd_parser.md
# apb_cmd_parser

Parametrised byte-stream to APB command parser. It sits between the host-side byte FIFO and the APB master. It pops a variable-length command frame (select, write flag, address, optional write data) and presents one complete command on a valid/ready handshake. Compared with the first-generation controller, it adds:
- configurable address and data widths;
- read frames with no data bytes;
- select range checking with frame drop;
- back-pressure from the APB master.

## Interface
Parameters:
- ADDR_BYTES, 4, address bytes per frame; p_addr is 8*ADDR_BYTES wide.
- DATA_BYTES, 4, write-data bytes per write frame; p_wdata is 8*DATA_BYTES wide.
- SEL_WIDTH, 2, width of p_sel.
- NUM_SLAVES, 3, highest legal select value. Legal range is 1..NUM_SLAVES; NUM_SLAVES ≤ 2**SEL_WIDTH-1.

Ports:
- rd_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- empty_flag  in  1  FIFO empty.
- fifo_data  in  8  FIFO read data, valid in the cycle after a cycle with rd_en=1.
- rd_en  out  1  FIFO pop strobe.
- p_sel  out  SEL_WIDTH  command slave select.
- p_write  out  1  1 = write, 0 = read.
- p_addr  out  8*ADDR_BYTES  command address.
- p_wdata  out  8*DATA_BYTES  write data; 0 for reads.
- o_valid  out  1  command available.
- m_ready  in  1  APB master accepts command.
- o_err  out  1  one-cycle pulse: frame dropped due to illegal select.
- o_busy  out  1  frame partially consumed, or command held.

## Operation
Frame byte order:
- Byte 0 is select; bits[SEL_WIDTH-1:0] are used and upper bits are ignored.
- Byte 1 is the write flag; bit0 is used and the rest are ignored.
- Next come ADDR_BYTES address bytes, MSB first.
- For write frames only, DATA_BYTES data bytes follow, MSB first. Read frames end after the address.

Byte fetch is a REQ/CAP pair:
- REQ: rd_en = ~empty_flag (combinational from state). The parser stays in REQ while empty_flag=1.
- CAP (always the following cycle): fifo_data is registered into the field addressed by the byte index.

States and transitions:
- SEL_REQ/SEL_CAP → WR_REQ/WR_CAP → ADDR_REQ/ADDR_CAP.
- ADDR_REQ/ADDR_CAP repeats until ADDR_BYTES bytes are captured.
- After the address: DATA_REQ/DATA_CAP if write=1, otherwise go straight to OUT.
- DATA_REQ/DATA_CAP repeats DATA_BYTES times, then OUT.

Byte index counter:
- Width is clog2(max(ADDR_BYTES, DATA_BYTES)) + 1.
- Clears on entry to the address and data phases.

Select check:
- An illegal select (0 or > NUM_SLAVES) sets an internal drop flag at SEL_CAP.
- The parser still consumes the remaining bytes of the frame, using the write flag to set frame length, so the stream stays aligned.
- At the end of the frame it pulses o_err for one cycle instead of entering OUT, then returns to SEL_REQ.

OUT state:
- o_valid=1; p_* stay stable.
- No FIFO reads occur while o_valid && !m_ready.
- On o_valid && m_ready, go to SEL_REQ; o_valid is 0 the next cycle.

Outputs:
- p_sel, p_write, p_addr and p_wdata are registered and update only on entering OUT.
- p_wdata is forced to 0 on read frames.

o_busy = (state ≠ SEL_REQ).

## Timing
- Reset values: rd_en=0, o_valid=0, o_err=0, o_busy=0, p_sel=0, p_write=0, p_addr=0, p_wdata=0; state=SEL_REQ, index=0, drop flag=0.
- Reset mid-frame: the partial frame is discarded and bytes already popped are lost. rd_en=0 in every cycle with rst=1. The bench resynchronises the FIFO.
- Minimum cycles per byte is 2. With the FIFO never empty and the first rd_en in cycle 0:
  - write frame: o_valid rises in cycle 2*(2+ADDR_BYTES+DATA_BYTES) = 20 at defaults;
  - read frame: o_valid rises in cycle 2*(2+ADDR_BYTES) = 12.
- After acceptance in cycle t, the next rd_en is no earlier than cycle t+1.
- empty_flag rising during REQ: rd_en drops in the same cycle and no byte is lost. The parser never issues rd_en while empty_flag=1.
- o_err asserts in the cycle after the last CAP of the dropped frame, and never in the same cycle as o_valid.
- m_ready is ignored while o_valid=0.

## Test plan
- Write frame 01,01,DE,AD,BE,EF,12,34,56,78 with m_ready=1 → o_valid in cycle 20 for 1 cycle; p_sel=1, p_write=1, p_addr=DEADBEEF, p_wdata=12345678; exactly 10 rd_en pulses.
- Read frame 02,00,00,00,10,04 then write frame 03,01,… → first command has p_write=0, p_addr=00001004, p_wdata=0 at cycle 12; second frame parses correctly, with no data bytes consumed for the read.
- Select 00 in a write frame, then a valid frame → o_err pulse after 10 bytes, no o_valid; the following frame is accepted intact. Repeat with select 03 when NUM_SLAVES=2.
- m_ready held 0 for 15 cycles after o_valid → p_* stable, rd_en=0 throughout; FIFO level unchanged until the accept cycle.
- empty_flag toggled every 3 cycles mid-address → rd_en never high while empty; final p_addr is correct.
- rst for 1 cycle after byte 4 of a frame, then a fresh frame → all outputs 0 after reset; the fresh frame parses correctly. Rerun with ADDR_BYTES=2, DATA_BYTES=8, SEL_WIDTH=3.
